// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neuron-network datapath blocks.
//   DFU_ADDR_W / DFU_DATA_W : default datapoint memory address / word widths
//   dfuState_t              : datapoint fetch unit FSM state
//   dfuCanIssue()           : read-issue credit check for the fetch unit
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int DFU_ADDR_W = 10;
    localparam int DFU_DATA_W = 18;

    typedef enum logic [1:0] {
        DFU_IDLE  = 2'd0,
        DFU_FETCH = 2'd1,
        DFU_DRAIN = 2'd2
    } dfuState_t;

    // A read may issue when the words already buffered, plus the word coming
    // back from memory this cycle, minus the word leaving this cycle, leave
    // room for one more. Counting the departing word keeps 1 word/cycle
    // throughput with a 1-cycle memory and a 1-cycle capture stage.
    function automatic logic dfuCanIssue(input logic [1:0] occupancy,
                                         input logic       inFlight,
                                         input logic       popping);
        logic [2:0] committed;
        committed = 3'(occupancy) + 3'(inFlight) - 3'(popping);
        return (committed < 3'd2);
    endfunction

endpackage

// File: rtl/dfu_fifo2.sv
// -----------------------------------------------------------------------------
// dfu_fifo2
// Two-entry buffer between the datapoint memory return path and the output
// stream. Write side is push-only (the writer tracks space via occupancy);
// read side is a valid/ready port driven from the head entry.
//   clock, reset   : clock, asynchronous active-high reset
//   inValid/inData : push a word this cycle (dropped if already full)
//   outValid/outReady/outData : head of buffer, popped on outValid && outReady
//   occupancy      : number of words held (0..2)
// -----------------------------------------------------------------------------
module dfu_fifo2 #(
    parameter int WIDTH = 19
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] headReg;
    logic [WIDTH-1:0] tailReg;
    logic [1:0]       occReg;
    logic             push;
    logic             pop;

    assign push      = inValid;
    assign pop       = outValid && outReady;
    assign outValid  = (occReg != 2'd0);
    assign outData   = headReg;
    assign occupancy = occReg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            headReg <= '0;
            tailReg <= '0;
            occReg  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occReg == 2'd0) begin
                        headReg <= inData;
                        occReg  <= 2'd1;
                    end else if (occReg == 2'd1) begin
                        tailReg <= inData;
                        occReg  <= 2'd2;
                    end
                end
                2'b01: begin
                    headReg <= tailReg;
                    occReg  <= occReg - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: head leaves, new word joins behind
                    // whatever remains.
                    if (occReg == 2'd1) begin
                        headReg <= inData;
                    end else begin
                        headReg <= tailReg;
                        tailReg <= inData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/datapoint_fetch_unit.sv
// -----------------------------------------------------------------------------
// datapoint_fetch_unit
// Fetches a burst of io_count datapoint words starting at io_baseAddr from a
// synchronous-read memory (data one cycle after address) and streams them to
// the neuron datapath, marking the final word with io_outLast.
//
// Ports:
//   clock, reset          : single clock, asynchronous active-high reset
//   io_start              : one-cycle burst request, ignored while busy
//   io_baseAddr, io_count : burst parameters, sampled with io_start
//   io_memAddr            : read address ((base + issued) mod 2^ADDR_W)
//   io_memWrEna           : memory write enable, always 0
//   io_memRdData          : memory read data
//   io_outValid/io_outReady/io_outData/io_outLast : output stream
//   io_busy               : high in FETCH and DRAIN
//   io_done               : one-cycle pulse when a burst finishes
//   io_stallCycles        : backpressure cycle counter
//   io_dbgState           : current FSM state (dfuState_t encoding)
//
// Stream handshake: a word moves when io_outValid && io_outReady are both
// high at a rising edge. Once io_outValid is raised, io_outData and
// io_outLast hold their values until that transfer; io_outValid never
// depends combinationally on io_outReady.
//
// Build option: define DFU_PERF_CNT_EN to enable the stall counter
// (cycles with io_outValid && !io_outReady, saturating, cleared on an
// accepted io_start). Without it io_stallCycles is tied to 0.
// -----------------------------------------------------------------------------
module datapoint_fetch_unit
    import nn_pkg::*;
#(
    parameter int ADDR_W = DFU_ADDR_W,
    parameter int DATA_W = DFU_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic [ADDR_W-1:0] io_baseAddr,
    input  logic [ADDR_W:0]   io_count,
    output logic [ADDR_W-1:0] io_memAddr,
    output logic              io_memWrEna,
    input  logic [DATA_W-1:0] io_memRdData,
    output logic              io_outValid,
    input  logic              io_outReady,
    output logic [DATA_W-1:0] io_outData,
    output logic              io_outLast,
    output logic              io_busy,
    output logic              io_done,
    output logic [15:0]       io_stallCycles,
    output logic [1:0]        io_dbgState
);

    dfuState_t         state;
    dfuState_t         nextState;

    logic [ADDR_W-1:0] baseReg;
    logic [ADDR_W:0]   countReg;
    logic [ADDR_W:0]   issued;
    logic              rdPending;
    logic              rdPendingLast;

    logic              startAccept;
    logic              zeroStart;
    logic              issue;
    logic              lastIssue;
    logic              popping;
    logic              lastTransfer;

    logic [1:0]        fifoOccupancy;
    logic              fifoOutValid;
    logic [DATA_W:0]   fifoOutData;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign startAccept  = (state == DFU_IDLE) && io_start && (io_count != '0);
    assign zeroStart    = (state == DFU_IDLE) && io_start && (io_count == '0);
    assign popping      = fifoOutValid && io_outReady;
    assign lastTransfer = popping && fifoOutData[DATA_W];
    assign lastIssue    = (issued == (countReg - {{ADDR_W{1'b0}}, 1'b1}));
    assign issue        = (state == DFU_FETCH) &&
                          dfuCanIssue(fifoOccupancy, rdPending, popping);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= DFU_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        nextState = state;
        case (state)
            DFU_IDLE: begin
                if (startAccept) begin
                    nextState = DFU_FETCH;
                end
            end
            DFU_FETCH: begin
                if (issue && lastIssue) begin
                    nextState = DFU_DRAIN;
                end
            end
            DFU_DRAIN: begin
                if (lastTransfer) begin
                    nextState = DFU_IDLE;
                end
            end
            default: begin
                nextState = DFU_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        io_busy     = 1'b0;
        io_dbgState = state;
        case (state)
            DFU_FETCH: io_busy = 1'b1;
            DFU_DRAIN: io_busy = 1'b1;
            default:   io_busy = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Burst registers and read pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baseReg       <= '0;
            countReg      <= '0;
            issued        <= '0;
            rdPending     <= 1'b0;
            rdPendingLast <= 1'b0;
        end else begin
            if (startAccept) begin
                baseReg  <= io_baseAddr;
                countReg <= io_count;
                issued   <= '0;
            end else if (issue) begin
                issued <= issued + {{ADDR_W{1'b0}}, 1'b1};
            end
            // Marks that io_memRdData carries a requested word next cycle;
            // the last flag travels with it into the buffer.
            rdPending     <= issue;
            rdPendingLast <= issue && lastIssue;
        end
    end

    // Address wraps naturally through the ADDR_W-bit add.
    assign io_memAddr  = baseReg + issued[ADDR_W-1:0];
    assign io_memWrEna = 1'b0;

    // ------------------------------------------------------------------
    // Done pulse: one cycle after the final transfer, or after a
    // zero-length request.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_done <= 1'b0;
        end else begin
            io_done <= zeroStart || ((state == DFU_DRAIN) && lastTransfer);
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    dfu_fifo2 #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .inValid   (rdPending),
        .inData    ({rdPendingLast, io_memRdData}),
        .outValid  (fifoOutValid),
        .outReady  (io_outReady),
        .outData   (fifoOutData),
        .occupancy (fifoOccupancy)
    );

    assign io_outValid = fifoOutValid;
    assign io_outData  = fifoOutData[DATA_W-1:0];
    assign io_outLast  = fifoOutValid && fifoOutData[DATA_W];

    // ------------------------------------------------------------------
    // Backpressure counter
    // ------------------------------------------------------------------
`ifdef DFU_PERF_CNT_EN
    logic [15:0] stallCnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCnt <= 16'd0;
        end else if (startAccept || zeroStart) begin
            stallCnt <= 16'd0;
        end else if (fifoOutValid && !io_outReady && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign io_stallCycles = stallCnt;
`else
    assign io_stallCycles = 16'd0;
`endif

endmodule
